seg7_rx_monitor: RTL and testbench
==================================

Name: seg7_rx_monitor

Overview:
- Receive side of the 7-segment GPIO interface driven by the board's decade-counter display.
- Samples the seven active-low segment lines {a,b,c,d,e,f,g} from an external source and filters glitches. Decodes each stable pattern back to a BCD digit.
- Checks that successive digits follow the 0..9 wrap-around count and flags stalls. Used for board-to-board loopback and self-test of display firmware.

Parameters:
- STABLE_CYCLES, 1000: consecutive identical synchronized samples required before a pattern is accepted (min 1).
- TIMEOUT_CYCLES, 40000000: cycles without a newly accepted pattern before `stalled` asserts (2x the display step period).
- CNT_W, 16: width of the error counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- seg_in  in  7  raw segment lines, bit6=a ... bit0=g; active-low, 0 = segment lit.
- clr_err  in  1  synchronous clear of err_count.
- digit  out  4  last accepted digit, 0..9.
- digit_valid  out  1  one-cycle pulse when a new digit is accepted.
- pattern_err  out  1  one-cycle pulse when an undecodable pattern is accepted.
- seq_err  out  1  one-cycle pulse when an accepted digit is not (previous+1) mod 10.
- locked  out  1  high in LOCKED or STALLED.
- stalled  out  1  high in STALLED.
- err_count  out  CNT_W  saturating count of pattern_err plus seq_err events.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low, named `rst_n`; clock port is `clk`. All logic is in the clk domain.
- Reset values: digit=4'hF, all pulses 0, locked=0, stalled=0, err_count=0. Synchronizer flops reset to 7'h7F (blank). Accepted pattern resets to 7'h7F. Filter and timeout counters reset to 0. State resets to UNLOCKED.
- Synchronizer: two flops on seg_in, giving seg_s.
- Filter:
  - `cand` holds the current candidate pattern and `stab_cnt` counts how long it has been stable.
  - If seg_s != cand, load cand=seg_s and stab_cnt=0.
  - Otherwise increment stab_cnt, saturating at STABLE_CYCLES-1.
  - Acceptance strobe: fires when stab_cnt==STABLE_CYCLES-1, seg_s==cand, and cand != accepted; then accepted<=cand.
  - Each distinct pattern is accepted once. Latency from the seg_in change to the output pulse is exactly STABLE_CYCLES+3 cycles.
- Decode table (a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 1111111 = blank.
  - Anything else = invalid.
- State machine (UNLOCKED, LOCKED, STALLED). Outputs are registered; each pulse is asserted in the cycle after acceptance.
  - UNLOCKED, valid digit: digit_valid=1, digit updated, go to LOCKED. No sequence check on this first digit.
  - UNLOCKED, invalid pattern: pattern_err=1, err_count+1, stay in UNLOCKED.
  - UNLOCKED, blank: no output.
  - LOCKED/STALLED, valid digit: digit_valid=1, digit updated. If digit != (prev+1) mod 10 (9 to 0 is legal), also seq_err=1 and err_count+1. Go to LOCKED.
  - LOCKED/STALLED, invalid pattern: pattern_err=1, err_count+1, go to UNLOCKED, digit=4'hF.
  - LOCKED/STALLED, blank: go to UNLOCKED, digit=4'hF, no error.
- Timeout:
  - to_cnt clears on every acceptance and whenever the state is UNLOCKED; otherwise it increments.
  - When to_cnt reaches TIMEOUT_CYCLES-1 in LOCKED, go to STALLED; stalled=1 from the next cycle.
  - STALLED holds until the next acceptance.
- err_count:
  - Saturates at all-ones.
  - clr_err has priority over a same-cycle increment, so the result is 0.
  - At most one increment per cycle.
- Reset mid-operation: everything returns immediately to reset values. The first pattern after release must still pass the full filter.

Decomposition:
- Package seg7_pkg holds the ten digit pattern constants, SEG_BLANK=7'h7F, and the state enum {UNLOCKED, LOCKED, STALLED}. It also holds a decode function returning {valid, blank, digit[3:0]}.
- Sub-module seg7_stable_filter (synchronizer + candidate/stab_cnt + acceptance strobe, outputs the accepted pattern and a strobe). Instantiated once.
- Top level contains decode, FSM, timeout and error counter.

Test Plan (bench uses STABLE_CYCLES=4, TIMEOUT_CYCLES=64):
- Reset, then drive the patterns for 0..9..0 with each held 20 cycles -> 11 digit_valid pulses, digits 0,1,...,9,0. Each pulse arrives exactly 7 cycles after the seg_in change. seq_err never fires; locked=1 after the first pulse.
- While locked on 3, apply a 3-cycle glitch to 7'b0000000, then return to 3 -> no pulses, digit stays 3.
- Sequence 4 then 6 -> seq_err pulse coincident with digit_valid (digit=6); err_count=1. Then 7 -> no error.
- Apply 7'b1111110 -> pattern_err=1, err_count+1, locked=0, digit=4'hF. Then 5 -> digit_valid, no seq_err, locked=1.
- Hold 2 for 100 cycles after acceptance -> stalled=1 exactly 65 cycles after the digit_valid cycle. Then 3 -> stalled=0, no seq_err.
- Force err_count=all-ones via repeated errors with CNT_W=2 -> saturates at 3. Assert clr_err in the same cycle as a seq_err -> err_count=0. Assert rst_n low mid-filter -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, monitor states and pattern decode
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  typedef enum logic [1:0] {UNLOCKED, LOCKED, STALLED} state_t;
  // returns {valid, blank, digit}
  function automatic logic [5:0] seg7_decode(input logic [6:0] p);
    case (p)
      SEG_0: return 6'b10_0000;
      SEG_1: return 6'b10_0001;
      SEG_2: return 6'b10_0010;
      SEG_3: return 6'b10_0011;
      SEG_4: return 6'b10_0100;
      SEG_5: return 6'b10_0101;
      SEG_6: return 6'b10_0110;
      SEG_7: return 6'b10_0111;
      SEG_8: return 6'b10_1000;
      SEG_9: return 6'b10_1001;
      SEG_BLANK: return 6'b01_1111;
      default: return 6'b00_1111;
    endcase
  endfunction
endpackage

// File: rtl/seg7_stable_filter.sv
// seg7_stable_filter: synchronizes segment lines and strobes each newly stable pattern once
module seg7_stable_filter #(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [6:0] pattern,
  output logic       strobe
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  logic [6:0] s1, seg_s, cand, accepted;
  logic [SW-1:0] stab_cnt;
  logic full;
  assign full = stab_cnt == SW'(STABLE_CYCLES - 1);
  assign strobe = full && seg_s == cand && cand != accepted;
  assign pattern = cand;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 7'h7F;
      seg_s <= 7'h7F;
      cand <= 7'h7F;
      accepted <= 7'h7F;
      stab_cnt <= '0;
    end else begin
      s1 <= seg_in;
      seg_s <= s1;
      if (seg_s != cand) begin
        cand <= seg_s;
        stab_cnt <= '0;
      end else if (!full) stab_cnt <= stab_cnt + 1'b1;
      if (strobe) accepted <= cand;
    end
  end
endmodule

// File: rtl/seg7_rx_monitor.sv
// seg7_rx_monitor: decodes filtered 7-segment patterns and checks the decade count sequence
module seg7_rx_monitor import seg7_pkg::*; #(
  parameter int STABLE_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 40000000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  input  logic             clr_err,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             pattern_err,
  output logic             seq_err,
  output logic             locked,
  output logic             stalled,
  output logic [CNT_W-1:0] err_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [6:0] pattern;
  logic strobe, seq_bad, err_inc;
  logic [5:0] dec;
  logic [3:0] nxt;
  logic [TW-1:0] to_cnt;
  state_t state;
  seg7_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .pattern(pattern), .strobe(strobe)
  );
  always_comb begin
    dec = seg7_decode(pattern);
    nxt = digit == 4'd9 ? 4'd0 : digit + 4'd1;
    seq_bad = state != UNLOCKED && dec[3:0] != nxt;
    err_inc = strobe && (dec[5] ? seq_bad : !dec[4]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNLOCKED;
      digit <= 4'hF;
      digit_valid <= 1'b0;
      pattern_err <= 1'b0;
      seq_err <= 1'b0;
      locked <= 1'b0;
      stalled <= 1'b0;
      to_cnt <= '0;
      err_count <= '0;
    end else begin
      digit_valid <= strobe && dec[5];
      pattern_err <= strobe && !dec[5] && !dec[4];
      seq_err <= strobe && dec[5] && seq_bad;
      locked <= state != UNLOCKED;
      stalled <= state == STALLED;
      to_cnt <= (strobe || state == UNLOCKED) ? '0 : to_cnt + 1'b1;
      if (strobe) begin
        digit <= dec[5] ? dec[3:0] : 4'hF;
        state <= dec[5] ? LOCKED : UNLOCKED;
      end else if (state == LOCKED && to_cnt == TW'(TIMEOUT_CYCLES - 1)) state <= STALLED;
      err_count <= clr_err ? '0 : (err_inc && !(&err_count)) ? err_count + 1'b1 : err_count;
    end
  end
endmodule

// File: tb/tb_seg7_rx_monitor.sv
// tb_seg7_rx_monitor: directed and random segment streams checked against an event-level model
module tb_seg7_rx_monitor;
  localparam int SC = 4;
  localparam int TO = 64;
  logic clk = 1'b0, rst_n = 1'b0, clr_err = 1'b0;
  logic [6:0] seg_in = 7'h7F;
  logic [3:0] digit, digit2;
  logic dv, pe, se, lk, st, dv2, pe2, se2, lk2, st2;
  logic [15:0] ec;
  logic [1:0] ec2;
  logic [6:0] pats [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  logic [6:0] acc;
  int checks = 0, errors = 0;
  int mst, since, mdig, cnt16, cnt2;

  seg7_rx_monitor #(.STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .clr_err(clr_err), .digit(digit),
    .digit_valid(dv), .pattern_err(pe), .seq_err(se), .locked(lk), .stalled(st), .err_count(ec)
  );
  seg7_rx_monitor #(.STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .clr_err(clr_err), .digit(digit2),
    .digit_valid(dv2), .pattern_err(pe2), .seq_err(se2), .locked(lk2), .stalled(st2), .err_count(ec2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    acc = 7'h7F;
    mst = 0;
    since = 0;
    mdig = 15;
    cnt16 = 0;
    cnt2 = 0;
  endtask

  task automatic chk_reset();
    chk("rst_digit", digit, 15);
    chk("rst_flags", {dv, pe, se, lk, st}, 0);
    chk("rst_cnt", ec, 0);
    chk("rst_dut2", {digit2, dv2, pe2, se2, lk2, st2, ec2}, 32'h1E0 << 2);
  endtask

  // one clock; acc_now marks the cycle in which the model expects the held pattern to be accepted
  task automatic tick(input logic acc_now, input logic [6:0] p);
    int lag, idx;
    logic clr_now, e_dv, e_pe, e_se;
    clr_now = clr_err;
    @(posedge clk);
    #1;
    lag = mst;
    e_dv = 0;
    e_pe = 0;
    e_se = 0;
    if (acc_now) begin
      acc = p;
      since = 0;
      idx = -1;
      for (int k = 0; k < 10; k++) if (pats[k] == p) idx = k;
      if (idx >= 0) begin
        e_dv = 1;
        e_se = mst != 0 && idx != (mdig + 1) % 10;
        mdig = idx;
        mst = 1;
      end else begin
        e_pe = p != 7'h7F;
        mst = 0;
        mdig = 15;
      end
    end else if (mst != 0) begin
      since++;
      if (mst == 1 && since == TO) mst = 2;
    end
    if (clr_now) begin
      cnt16 = 0;
      cnt2 = 0;
    end else if (e_pe || e_se) begin
      if (cnt16 < 65535) cnt16++;
      if (cnt2 < 3) cnt2++;
    end
    chk("digit_valid", dv, e_dv);
    chk("pattern_err", pe, e_pe);
    chk("seq_err", se, e_se);
    chk("digit", digit, mdig);
    chk("locked", lk, lag != 0);
    chk("stalled", st, lag == 2);
    chk("err_count", ec, cnt16);
    chk("dut2", {digit2, dv2, pe2, se2, lk2, st2, ec2},
        {mdig[3:0], e_dv, e_pe, e_se, lag != 0, lag == 2, cnt2[1:0]});
  endtask

  task automatic step(input logic [6:0] p, input int h, input int clr_at);
    logic pend;
    seg_in = p;
    pend = h >= 10 && p != acc;
    for (int i = 0; i < h; i++) begin
      clr_err = i == clr_at;
      tick(pend && i == SC + 2, p);
    end
    clr_err = 1'b0;
  endtask

  initial begin
    logic [6:0] p;
    int r, h, c;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    for (int d = 0; d < 10; d++) step(pats[d], 20, -1);
    step(pats[0], 20, -1);
    for (int d = 1; d < 4; d++) step(pats[d], 20, -1);
    step(7'b0000000, 3, -1);
    step(pats[3], 20, -1);
    step(pats[4], 20, -1);
    step(pats[6], 20, -1);
    step(pats[7], 20, -1);
    step(7'b1111110, 20, -1);
    step(pats[5], 20, -1);
    step(pats[6], 20, -1);
    step(pats[2], 100, -1);
    step(pats[3], 20, -1);
    for (int k = 0; k < 3; k++) begin
      step(7'b1111110, 20, -1);
      step(7'b1111101, 20, -1);
    end
    step(pats[5], 20, -1);
    step(pats[8], 20, SC + 2);
    step(pats[9], 20, -1);
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3 && mdig < 10) p = pats[(mdig + 1) % 10];
      else if (r < 6) p = pats[$urandom_range(0, 9)];
      else if (r == 6) p = 7'h7F;
      else p = 7'($urandom);
      if (p == seg_in) p = p ^ 7'h01;
      h = r >= 8 ? $urandom_range(1, 3) : $urandom_range(10, 90);
      c = $urandom_range(0, 7) == 0 ? $urandom_range(0, h - 1) : -1;
      step(p, h, c);
    end
    step(pats[1], 20, -1);
    seg_in = pats[2];
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset();
    @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;
    mreset();
    step(pats[4], 20, -1);
    step(pats[5], 20, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
